vortex_ctrl_axil_master: RTL and testbench

Sequencer that turns single-beat register commands from the NoC-side bridge into AXI4-Lite transactions on the Vortex control port. It owns the master side of the Vortex control bus and drives the AW, W, B, AR and R channels. Only one transaction is outstanding at a time. Each completed transaction returns one response (read data plus error flag) to the requester.

---
 rtl/vortex_ctrl_pkg.sv | 32 +++
 rtl/vortex_ctrl_axil_master_if.sv | 42 ++++
 rtl/vortex_ctrl_timeout_cnt.sv | 45 ++++
 rtl/vortex_ctrl_axil_master.sv | 178 +++++++++++++++++
 tb/tb_vortex_ctrl_axil_master.sv | 327 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vortex_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// vortex_ctrl_pkg
// Shared definitions for the Vortex control-port AXI4-Lite master:
//   - state_e     : sequencer state encoding (3-bit)
//   - AXI_RESP_*  : AXI4-Lite response codes
//   - VC_*        : default widths and watchdog limit
//   - resp_is_err : maps a BRESP/RRESP code to the requester's error flag
// -----------------------------------------------------------------------------
package vortex_ctrl_pkg;

    localparam int unsigned VC_ADDR_WIDTH     = 8;
    localparam int unsigned VC_DATA_WIDTH     = 32;
    localparam int unsigned VC_TIMEOUT_CYCLES = 1024;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_REQ  = 3'd1,
        ST_WR_RESP = 3'd2,
        ST_RD_REQ  = 3'd3,
        ST_RD_RESP = 3'd4,
        ST_RSP     = 3'd5
    } state_e;

    // Anything other than OKAY (SLVERR, DECERR, EXOKAY) is reported as an error.
    function automatic logic resp_is_err(input logic [1:0] resp);
        return resp != AXI_RESP_OKAY;
    endfunction

endpackage

// File: rtl/vortex_ctrl_axil_master_if.sv
// -----------------------------------------------------------------------------
// vortex_ctrl_axil_master_if
// AXI4-Lite control bus between the sequencer (master) and the Vortex control
// registers (slave).
//   AW : awvalid, awready, awaddr
//   W  : wvalid, wready, wdata, wstrb
//   B  : bvalid, bready, bresp
//   AR : arvalid, arready, araddr
//   R  : rvalid, rready, rdata, rresp
// -----------------------------------------------------------------------------
interface vortex_ctrl_axil_master_if #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 32
);
    logic                    awvalid;
    logic                    awready;
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic                    wvalid;
    logic                    wready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    bvalid;
    logic                    bready;
    logic [1:0]              bresp;
    logic                    arvalid;
    logic                    arready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic                    rvalid;
    logic                    rready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;

    modport master (
        output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport slave (
        input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/vortex_ctrl_timeout_cnt.sv
// -----------------------------------------------------------------------------
// vortex_ctrl_timeout_cnt
// Per-transaction watchdog. Used only when VORTEX_CTRL_TIMEOUT_EN is defined.
//   clk, rst   : clock, asynchronous active-high reset
//   clear_i    : restart the count (command accepted)
//   en_i       : count this cycle (transaction in flight)
//   expired_o  : this cycle's increment brings the count to TIMEOUT_CYCLES-1;
//                the sequencer abandons the transaction on this edge
// TIMEOUT_CYCLES must be at least 2.
// -----------------------------------------------------------------------------
module vortex_ctrl_timeout_cnt #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic en_i,
    output logic expired_o
);
    localparam int unsigned      CW    = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CW-1:0]    LIMIT = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Expire on the edge where the count lands on the limit, so the response
    // appears TIMEOUT_CYCLES cycles after the accept cycle.
    assign expired_o = en_i && ((cnt_q + CW'(1)) == LIMIT);

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/vortex_ctrl_axil_master.sv
// -----------------------------------------------------------------------------
// vortex_ctrl_axil_master
// Turns single-beat register commands into AXI4-Lite transactions on the
// Vortex control port, one transaction outstanding at a time, and returns one
// response (read data + error flag) per command.
//   clk, rst             : clock, asynchronous active-high reset
//   cmd_valid_i/ready_o  : command handshake; cmd_we_i/addr_i/wdata_i/wstrb_i
//   rsp_valid_o/ready_i  : response handshake; rsp_rdata_o (0 for writes), rsp_err_o
//   busy_o               : sequencer not idle
//   m_axi_ctrl           : AXI4-Lite master (AW, W, B, AR, R)
// Optional feature: define VORTEX_CTRL_TIMEOUT_EN to add a per-transaction
// watchdog of TIMEOUT_CYCLES cycles; without it transactions wait forever.
// -----------------------------------------------------------------------------
module vortex_ctrl_axil_master
    import vortex_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = VC_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH     = VC_DATA_WIDTH,
    parameter int unsigned TIMEOUT_CYCLES = VC_TIMEOUT_CYCLES
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid_i,
    output logic                    cmd_ready_o,
    input  logic                    cmd_we_i,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr_i,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata_i,
    input  logic [DATA_WIDTH/8-1:0] cmd_wstrb_i,
    output logic                    rsp_valid_o,
    input  logic                    rsp_ready_i,
    output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
    output logic                    rsp_err_o,
    output logic                    busy_o,
    vortex_ctrl_axil_master_if.master m_axi_ctrl
);
    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [DATA_WIDTH/8-1:0] wstrb_q, wstrb_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    err_q, err_d;
    logic                    aw_done_q, aw_done_d;
    logic                    w_done_q, w_done_d;

    logic accept, in_flight, timeout;
    logic awvalid, wvalid, bready, arvalid, rready;
    logic aw_hs, w_hs;

    // cmd_ready_o is forced low while reset is held so every ready/valid
    // output is 0 during reset, not only after the first clock.
    assign cmd_ready_o = (state_q == ST_IDLE) && !rst;
    assign accept      = cmd_valid_i && cmd_ready_o;
    assign in_flight   = (state_q == ST_WR_REQ) || (state_q == ST_WR_RESP) ||
                         (state_q == ST_RD_REQ) || (state_q == ST_RD_RESP);

`ifdef VORTEX_CTRL_TIMEOUT_EN
    vortex_ctrl_timeout_cnt #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout_cnt (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (accept),
        .en_i      (in_flight),
        .expired_o (timeout)
    );
`else
    // No watchdog: folds to constant 0 for any legal (non-zero) limit.
    assign timeout = (TIMEOUT_CYCLES == 0);
`endif

    // Channel controls decode from registered state only; a timeout drops
    // them in the cycle the transaction is abandoned.
    assign awvalid = (state_q == ST_WR_REQ)  && !aw_done_q && !timeout;
    assign wvalid  = (state_q == ST_WR_REQ)  && !w_done_q  && !timeout;
    assign bready  = (state_q == ST_WR_RESP) && !timeout;
    assign arvalid = (state_q == ST_RD_REQ)  && !timeout;
    assign rready  = (state_q == ST_RD_RESP) && !timeout;
    assign aw_hs   = awvalid && m_axi_ctrl.awready;
    assign w_hs    = wvalid  && m_axi_ctrl.wready;

    assign m_axi_ctrl.awvalid = awvalid;
    assign m_axi_ctrl.awaddr  = addr_q;
    assign m_axi_ctrl.wvalid  = wvalid;
    assign m_axi_ctrl.wdata   = wdata_q;
    assign m_axi_ctrl.wstrb   = wstrb_q;
    assign m_axi_ctrl.bready  = bready;
    assign m_axi_ctrl.arvalid = arvalid;
    assign m_axi_ctrl.araddr  = addr_q;
    assign m_axi_ctrl.rready  = rready;

    assign rsp_valid_o = (state_q == ST_RSP);
    assign rsp_rdata_o = rdata_q;
    assign rsp_err_o   = err_q;
    assign busy_o      = (state_q != ST_IDLE);

    always_comb begin
        // NOTE: every variable gets its hold value before the case so no
        // path through the block leaves one unassigned (which would infer a latch).
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;

        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    addr_d    = cmd_addr_i;
                    wdata_d   = cmd_wdata_i;
                    wstrb_d   = cmd_wstrb_i;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = cmd_we_i ? ST_WR_REQ : ST_RD_REQ;
                end
            end
            ST_WR_REQ: begin
                if (aw_hs) aw_done_d = 1'b1;
                if (w_hs)  w_done_d  = 1'b1;
                // Both handshakes may land on the same edge or in either order.
                if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) state_d = ST_WR_RESP;
            end
            ST_WR_RESP: begin
                if (bready && m_axi_ctrl.bvalid) begin
                    rdata_d = '0;
                    err_d   = resp_is_err(m_axi_ctrl.bresp);
                    state_d = ST_RSP;
                end
            end
            ST_RD_REQ: begin
                if (arvalid && m_axi_ctrl.arready) state_d = ST_RD_RESP;
            end
            ST_RD_RESP: begin
                if (rready && m_axi_ctrl.rvalid) begin
                    rdata_d = m_axi_ctrl.rdata;
                    err_d   = resp_is_err(m_axi_ctrl.rresp);
                    state_d = ST_RSP;
                end
            end
            ST_RSP: begin
                if (rsp_ready_i) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (timeout) begin
            rdata_d = '0;
            err_d   = 1'b1;
            state_d = ST_RSP;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values regardless of statement order.
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end
endmodule

// File: tb/tb_vortex_ctrl_axil_master.sv
// -----------------------------------------------------------------------------
// tb_vortex_ctrl_axil_master
// Directed bench for vortex_ctrl_axil_master. Inputs change and outputs are
// sampled on the falling edge; expected values are hand-computed per step.
// The watchdog scenario is included when VORTEX_CTRL_TIMEOUT_EN is defined.
// -----------------------------------------------------------------------------
module tb_vortex_ctrl_axil_master;
    logic        clk;
    logic        rst;
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic        cmd_we_i;
    logic [7:0]  cmd_addr_i;
    logic [31:0] cmd_wdata_i;
    logic [3:0]  cmd_wstrb_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;
    logic        busy_o;

    int vectors;
    int miscompares;

    vortex_ctrl_axil_master_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) axi ();

    vortex_ctrl_axil_master #(
        .ADDR_WIDTH     (8),
        .DATA_WIDTH     (32),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid_i (cmd_valid_i),
        .cmd_ready_o (cmd_ready_o),
        .cmd_we_i    (cmd_we_i),
        .cmd_addr_i  (cmd_addr_i),
        .cmd_wdata_i (cmd_wdata_i),
        .cmd_wstrb_i (cmd_wstrb_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_rdata_o (rsp_rdata_o),
        .rsp_err_o   (rsp_err_o),
        .busy_o      (busy_o),
        .m_axi_ctrl  (axi)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "bench timeout");
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Advance one clock and land on the following falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic issue(input logic we, input logic [7:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb);
        cmd_valid_i = 1'b1;
        cmd_we_i    = we;
        cmd_addr_i  = addr;
        cmd_wdata_i = wdata;
        cmd_wstrb_i = wstrb;
        step();
        cmd_valid_i = 1'b0;
    endtask

    task automatic consume();
        rsp_ready_i = 1'b1;
        step();
        rsp_ready_i = 1'b0;
    endtask

    initial begin
        vectors      = 0;
        miscompares  = 0;
        rst          = 1'b1;
        cmd_valid_i  = 1'b0;
        cmd_we_i     = 1'b0;
        cmd_addr_i   = '0;
        cmd_wdata_i  = '0;
        cmd_wstrb_i  = '0;
        rsp_ready_i  = 1'b0;
        axi.awready  = 1'b0;
        axi.wready   = 1'b0;
        axi.bvalid   = 1'b0;
        axi.bresp    = 2'b00;
        axi.arready  = 1'b0;
        axi.rvalid   = 1'b0;
        axi.rdata    = '0;
        axi.rresp    = 2'b00;

        // ---- reset state ----
        #3;
        check("rst_cmd_ready", cmd_ready_o, 0);
        check("rst_rsp_valid", rsp_valid_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_awvalid", axi.awvalid, 0);
        check("rst_wvalid", axi.wvalid, 0);
        check("rst_arvalid", axi.arvalid, 0);
        check("rst_bready", axi.bready, 0);
        check("rst_rready", axi.rready, 0);
        check("rst_rdata", rsp_rdata_o, 0);
        check("rst_err", rsp_err_o, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("idle_cmd_ready", cmd_ready_o, 1);
        @(negedge clk);

        // ---- write, zero-wait slave ----
        axi.awready = 1'b1;
        axi.wready  = 1'b1;
        axi.bvalid  = 1'b1;
        axi.bresp   = 2'b00;
        issue(1'b1, 8'h04, 32'hDEADBEEF, 4'hF);
        check("w0_awvalid", axi.awvalid, 1);
        check("w0_wvalid", axi.wvalid, 1);
        check("w0_awaddr", axi.awaddr, 32'h04);
        check("w0_wdata", axi.wdata, 32'hDEADBEEF);
        check("w0_wstrb", axi.wstrb, 32'hF);
        check("w0_cmd_ready", cmd_ready_o, 0);
        check("w0_busy", busy_o, 1);
        step();
        check("w0_awvalid_drop", axi.awvalid, 0);
        check("w0_wvalid_drop", axi.wvalid, 0);
        check("w0_bready", axi.bready, 1);
        check("w0_rsp_early", rsp_valid_o, 0);
        step();
        check("w0_rsp_valid", rsp_valid_o, 1);
        check("w0_err", rsp_err_o, 0);
        check("w0_rdata", rsp_rdata_o, 0);
        check("w0_bready_off", axi.bready, 0);
        consume();
        check("w0_rsp_gone", rsp_valid_o, 0);
        check("w0_cmd_ready", cmd_ready_o, 1);
        check("w0_idle", busy_o, 0);

        // ---- write, W handshake 3 cycles before AW ----
        axi.awready = 1'b0;
        axi.wready  = 1'b1;
        axi.bvalid  = 1'b0;
        issue(1'b1, 8'h08, 32'hCAFEF00D, 4'h3);
        check("wa_both_valid", {axi.awvalid, axi.wvalid}, 2'b11);
        step();
        check("wa_w_dropped", {axi.awvalid, axi.wvalid}, 2'b10);
        axi.wready = 1'b0;
        step();
        check("wa_wait1", {axi.awvalid, axi.wvalid}, 2'b10);
        step();
        check("wa_wait2", {axi.awvalid, axi.wvalid}, 2'b10);
        axi.awready = 1'b1;
        step();
        check("wa_aw_dropped", {axi.awvalid, axi.wvalid}, 2'b00);
        check("wa_bready", axi.bready, 1);
        axi.awready = 1'b0;
        axi.bvalid  = 1'b1;
        step();
        check("wa_rsp_valid", rsp_valid_o, 1);
        axi.bvalid = 1'b0;
        consume();
        step();
        check("wa_single_rsp", rsp_valid_o, 0);

        // ---- write, AW handshake 3 cycles before W ----
        axi.awready = 1'b1;
        axi.wready  = 1'b0;
        issue(1'b1, 8'h0C, 32'h01020304, 4'hC);
        check("wb_both_valid", {axi.awvalid, axi.wvalid}, 2'b11);
        step();
        check("wb_aw_dropped", {axi.awvalid, axi.wvalid}, 2'b01);
        axi.awready = 1'b0;
        step();
        check("wb_wait1", {axi.awvalid, axi.wvalid}, 2'b01);
        step();
        check("wb_wait2", {axi.awvalid, axi.wvalid}, 2'b01);
        axi.wready = 1'b1;
        step();
        check("wb_w_dropped", {axi.awvalid, axi.wvalid}, 2'b00);
        axi.wready = 1'b0;
        axi.bvalid = 1'b1;
        step();
        check("wb_rsp_valid", rsp_valid_o, 1);
        axi.bvalid = 1'b0;
        consume();
        step();
        check("wb_single_rsp", rsp_valid_o, 0);

        // ---- read with AR delay and response backpressure ----
        issue(1'b0, 8'h10, 32'h0, 4'h0);
        check("rd_arvalid", axi.arvalid, 1);
        check("rd_araddr", axi.araddr, 32'h10);
        for (int i = 1; i <= 4; i++) begin
            step();
            check("rd_ar_hold", axi.arvalid, 1);
        end
        axi.arready = 1'b1;
        step();
        check("rd_ar_dropped", axi.arvalid, 0);
        check("rd_rready", axi.rready, 1);
        axi.arready = 1'b0;
        axi.rvalid  = 1'b1;
        axi.rdata   = 32'h12345678;
        axi.rresp   = 2'b00;
        step();
        check("rd_rsp_valid", rsp_valid_o, 1);
        check("rd_rdata", rsp_rdata_o, 32'h12345678);
        check("rd_err", rsp_err_o, 0);
        check("rd_rready_off", axi.rready, 0);
        axi.rvalid  = 1'b0;
        axi.rdata   = 32'hFFFFFFFF;
        cmd_valid_i = 1'b1;
        cmd_we_i    = 1'b0;
        cmd_addr_i  = 8'h20;
        for (int i = 0; i < 4; i++) begin
            step();
            check("rd_hold_valid", rsp_valid_o, 1);
            check("rd_hold_rdata", rsp_rdata_o, 32'h12345678);
            check("rd_hold_cmd_ready", cmd_ready_o, 0);
        end
        cmd_valid_i = 1'b0;
        consume();
        check("rd_consumed", rsp_valid_o, 0);
        check("rd_cmd_ready", cmd_ready_o, 1);

        // ---- error responses ----
        axi.arready = 1'b1;
        axi.rvalid  = 1'b1;
        axi.rdata   = 32'hAAAA5555;
        axi.rresp   = 2'b10;
        issue(1'b0, 8'h14, 32'h0, 4'h0);
        step();
        step();
        check("rerr_rsp_valid", rsp_valid_o, 1);
        check("rerr_err", rsp_err_o, 1);
        check("rerr_rdata", rsp_rdata_o, 32'hAAAA5555);
        axi.arready = 1'b0;
        axi.rvalid  = 1'b0;
        axi.rresp   = 2'b00;
        consume();
        axi.awready = 1'b1;
        axi.wready  = 1'b1;
        axi.bvalid  = 1'b1;
        axi.bresp   = 2'b11;
        issue(1'b1, 8'h18, 32'h55, 4'h1);
        step();
        step();
        check("werr_rsp_valid", rsp_valid_o, 1);
        check("werr_err", rsp_err_o, 1);
        check("werr_rdata", rsp_rdata_o, 0);
        axi.awready = 1'b0;
        axi.wready  = 1'b0;
        axi.bvalid  = 1'b0;
        axi.bresp   = 2'b00;
        consume();

        // ---- reset during RD_RESP ----
        axi.arready = 1'b1;
        issue(1'b0, 8'h2C, 32'h0, 4'h0);
        step();
        axi.arready = 1'b0;
        check("rr_in_rd_resp", axi.rready, 1);
        rst = 1'b1;
        #1;
        check("rr_rready", axi.rready, 0);
        check("rr_busy", busy_o, 0);
        check("rr_cmd_ready", cmd_ready_o, 0);
        check("rr_rsp_valid", rsp_valid_o, 0);
        check("rr_araddr", axi.araddr, 0);
        check("rr_err", rsp_err_o, 0);
        step();
        rst = 1'b0;
        #1;
        check("rr_cmd_ready_after", cmd_ready_o, 1);
        check("rr_no_rsp", rsp_valid_o, 0);
        @(negedge clk);
        axi.arready = 1'b1;
        axi.rvalid  = 1'b1;
        axi.rdata   = 32'h0BADC0DE;
        axi.rresp   = 2'b00;
        issue(1'b0, 8'h30, 32'h0, 4'h0);
        check("rr2_araddr", axi.araddr, 32'h30);
        step();
        step();
        check("rr2_rsp_valid", rsp_valid_o, 1);
        check("rr2_rdata", rsp_rdata_o, 32'h0BADC0DE);
        check("rr2_err", rsp_err_o, 0);
        axi.arready = 1'b0;
        axi.rvalid  = 1'b0;
        consume();

`ifdef VORTEX_CTRL_TIMEOUT_EN
        // ---- watchdog: slave never answers AR (limit 16) ----
        issue(1'b0, 8'h40, 32'h0, 4'h0);
        for (int i = 1; i <= 14; i++) begin
            step();
            check("to_no_rsp", rsp_valid_o, 0);
            check("to_arvalid", axi.arvalid, (i < 14) ? 1 : 0);
        end
        step();
        check("to_rsp_valid", rsp_valid_o, 1);
        check("to_err", rsp_err_o, 1);
        check("to_rdata", rsp_rdata_o, 0);
        check("to_arvalid_off", axi.arvalid, 0);
        consume();
        check("to_idle", cmd_ready_o, 1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
